// File: rtl/seg_disp_arbiter.sv
// Time-shares one 6-digit display between an alarm source (0, preempting) and two value sources.
// Optional blinking of source 0 when SEG_ARB_BLINK_EN is defined.
module seg_disp_arbiter #(
  parameter int CNT_1MS  = 50000,
  parameter int SLOT_MS  = 2000,
  parameter int BLANK_MS = 100,
  parameter int BLINK_MS = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [23:0] data0,
  input  logic [23:0] data1,
  input  logic [23:0] data2,
  input  logic [5:0]  point0,
  input  logic [5:0]  point1,
  input  logic [5:0]  point2,
  output logic [2:0]  gnt,
  output logic [23:0] seg_data_6,
  output logic [5:0]  point,
  output logic        seg_en
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  localparam int CYC_W  = $clog2(CNT_1MS + 1);
  localparam int MS_MAX = (SLOT_MS > BLANK_MS) ? SLOT_MS : BLANK_MS;
  localparam int MS_W   = $clog2(MS_MAX + 1);

  if (CNT_1MS < 1 || SLOT_MS < 1 || BLANK_MS < 1 || BLINK_MS < 1) begin : g_bad_param
    $error("seg_disp_arbiter: all timing parameters must be >= 1");
  end

  logic [1:0]       r_state;
  logic [1:0]       r_cur;
  logic [CYC_W-1:0] r_cyc;
  logic [MS_W-1:0]  r_ms;

  logic [1:0]  w_nstate;
  logic [1:0]  w_ncur;
  logic [1:0]  w_cur;
  logic [1:0]  w_n1;
  logic [1:0]  w_n2;
  logic        w_clr;
  logic        w_tick;
  logic        w_slot_end;
  logic        w_blank_end;
  logic        w_en_show;
  logic [23:0] w_sel_data;
  logic [5:0]  w_sel_point;

  function automatic logic [1:0] inc3(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : 2'(c + 2'd1);
  endfunction

  // An illegal index 3 is folded onto source 0.
  assign w_cur       = (r_cur == 2'd3) ? 2'd0 : r_cur;
  assign w_n1        = inc3(w_cur);
  assign w_n2        = inc3(w_n1);
  assign w_tick      = (r_cyc == CYC_W'(CNT_1MS - 1));
  assign w_slot_end  = w_tick && (r_ms == MS_W'(SLOT_MS - 1));
  assign w_blank_end = w_tick && (r_ms == MS_W'(BLANK_MS - 1));

  always_comb begin
    w_nstate = r_state;
    w_ncur   = w_cur;
    w_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_nstate = S_SHOW;
          w_ncur   = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
          w_clr    = 1'b1;
        end
      end
      S_SHOW: begin
        if (req[0] && w_cur != 2'd0) begin
          w_ncur = 2'd0;
          w_clr  = 1'b1;
        end else if (!req[w_cur]) begin
          w_nstate = S_BLANK;
          w_clr    = 1'b1;
        end else if (w_slot_end) begin
          // Another requester waits: go dark first; otherwise re-grant in place.
          if (req[w_n1] || req[w_n2]) w_nstate = S_BLANK;
          w_clr = 1'b1;
        end
      end
      S_BLANK: begin
        if (req[0]) begin
          w_nstate = S_SHOW;
          w_ncur   = 2'd0;
          w_clr    = 1'b1;
        end else if (w_blank_end) begin
          w_clr = 1'b1;
          if (req[w_n1]) begin
            w_nstate = S_SHOW;
            w_ncur   = w_n1;
          end else if (req[w_n2]) begin
            w_nstate = S_SHOW;
            w_ncur   = w_n2;
          end else if (req[w_cur]) begin
            w_nstate = S_SHOW;
          end else begin
            w_nstate = S_IDLE;
          end
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_ncur   = 2'd0;
        w_clr    = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (w_ncur)
      2'd1:    begin w_sel_data = data1; w_sel_point = point1; end
      2'd2:    begin w_sel_data = data2; w_sel_point = point2; end
      default: begin w_sel_data = data0; w_sel_point = point0; end
    endcase
  end

`ifdef SEG_ARB_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_MS + 1);

  logic [BLINK_W-1:0] r_bms;
  logic               r_phase;
  logic               w_bwrap;
  logic               w_nphase;

  assign w_bwrap = w_tick && (r_bms == BLINK_W'(BLINK_MS - 1));

  always_comb begin
    w_nphase = r_phase;
    if (w_clr)        w_nphase = 1'b1;
    else if (w_bwrap) w_nphase = ~r_phase;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bms   <= '0;
      r_phase <= 1'b1;
    end else begin
      r_phase <= w_nphase;
      if (w_clr || w_bwrap) r_bms <= '0;
      else if (w_tick)      r_bms <= r_bms + 1'b1;
    end
  end

  assign w_en_show = (w_ncur != 2'd0) || w_nphase;
`else
  assign w_en_show = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cur      <= 2'd0;
      r_cyc      <= '0;
      r_ms       <= '0;
      gnt        <= 3'b000;
      seg_data_6 <= 24'h0;
      point      <= 6'h0;
      seg_en     <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cur   <= w_ncur;
      if (w_clr || w_tick) r_cyc <= '0;
      else                 r_cyc <= r_cyc + 1'b1;
      if (w_clr)       r_ms <= '0;
      else if (w_tick) r_ms <= r_ms + 1'b1;
      // Outputs follow the next state so they change on the same edge as the FSM.
      gnt    <= (w_nstate == S_SHOW) ? (3'b001 << w_ncur) : 3'b000;
      seg_en <= (w_nstate == S_SHOW) && w_en_show;
      if (w_nstate == S_SHOW) begin
        seg_data_6 <= w_sel_data;
        point      <= w_sel_point;
      end else if (w_nstate == S_IDLE) begin
        seg_data_6 <= 24'h0;
        point      <= 6'h0;
      end
    end
  end

endmodule
